// File: rtl/input_frame_loader.sv
// -----------------------------------------------------------------------------
// input_frame_loader
//
// Collects a stream of signed (3,5) fixed-point samples into a frame buffer
// that drives the accelerator inputs directly. When a frame of exactly
// NUM_INPUTS samples closes with s_last, the loader pulses ready_for_inf. It
// then holds the frame steady until the accelerator reports fp_done. After
// that it pulses acc_rst to return the accelerator to idle and starts
// collecting the next frame.
//
// Handshake: a sample transfers on every rising edge where s_valid_i and
// s_ready_o are both high. s_ready_o comes from a register and never depends
// on s_valid_i in the same cycle. It is high only while the loader is filling.
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous, active-high reset
//   s_valid_i        upstream sample valid
//   s_ready_o        loader accepts a sample this cycle
//   s_data_i         signed sample
//   s_last_i         final sample of a frame
//   frame_o          frame buffer, [0:NUM_INPUTS-1]
//   ready_for_inf_o  one-cycle start pulse to the accelerator
//   fp_done_i        accelerator forward pass complete (level)
//   acc_rst_o        one-cycle reset pulse to the accelerator
//   frame_err_o      one-cycle pulse on a short or long frame
//   frames_done_o    completed inference count, wraps at 16 bits
//   state_o          debug: current FSM state (0 FILL, 1 START, 2 BUSY, 3 RELEASE)
//   wr_idx_o         debug: next frame slot to be written
// -----------------------------------------------------------------------------
module input_frame_loader #(
    parameter int NUM_INPUTS = 256,
    parameter int DATA_WIDTH = 8,
    localparam int IDX_W = $clog2(NUM_INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic signed [DATA_WIDTH-1:0] s_data_i,
    input  logic                         s_last_i,
    output logic signed [DATA_WIDTH-1:0] frame_o [0:NUM_INPUTS-1],
    output logic                         ready_for_inf_o,
    input  logic                         fp_done_i,
    output logic                         acc_rst_o,
    output logic                         frame_err_o,
    output logic [15:0]                  frames_done_o,
    output logic [1:0]                   state_o,
    output logic [IDX_W-1:0]             wr_idx_o
);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    state_t                        state_q;
    logic [IDX_W-1:0]              wr_idx_q;
    logic [IDX_W-1:0]              wr_idx_d;
    logic signed [DATA_WIDTH-1:0]  frame_q [0:NUM_INPUTS-1];
    logic [15:0]                   frames_done_q;
    logic                          s_ready_q;
    logic                          ready_for_inf_q;
    logic                          acc_rst_q;
    logic                          frame_err_q;

    logic accept;
    logic at_end;

    // Both a proper close and either framing error restart the write index,
    // so a short or long frame never leaks its position into the next frame.
    always_comb begin
        accept   = s_valid_i & s_ready_q;
        at_end   = (wr_idx_q == LAST_IDX);
        wr_idx_d = wr_idx_q;
        if (accept) begin
            if (at_end || s_last_i) begin
                wr_idx_d = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= FILL;
            wr_idx_q        <= '0;
            frames_done_q   <= '0;
            s_ready_q       <= 1'b1;
            ready_for_inf_q <= 1'b0;
            acc_rst_q       <= 1'b0;
            frame_err_q     <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            // Pulse outputs are high for one cycle only unless re-armed below.
            ready_for_inf_q <= 1'b0;
            acc_rst_q       <= 1'b0;
            frame_err_q     <= 1'b0;
            wr_idx_q        <= wr_idx_d;

            case (state_q)
                FILL: begin
                    if (accept) begin
                        frame_q[wr_idx_q] <= s_data_i;
                        if (at_end && s_last_i) begin
                            state_q         <= START;
                            ready_for_inf_q <= 1'b1;
                            s_ready_q       <= 1'b0;
                        end else if (at_end || s_last_i) begin
                            // Short frame (early s_last) or long frame
                            // (full buffer without s_last).
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                START: begin
                    // fp_done is ignored here: it can only belong to a
                    // previous, already released inference.
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (fp_done_i) begin
                        state_q       <= RELEASE;
                        acc_rst_q     <= 1'b1;
                        frames_done_q <= frames_done_q + 16'd1;
                    end
                end
                RELEASE: begin
                    state_q   <= FILL;
                    s_ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= FILL;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready_o       = s_ready_q;
    assign frame_o         = frame_q;
    assign ready_for_inf_o = ready_for_inf_q;
    assign acc_rst_o       = acc_rst_q;
    assign frame_err_o     = frame_err_q;
    assign frames_done_o   = frames_done_q;
    assign state_o         = state_q;
    assign wr_idx_o        = wr_idx_q;

endmodule

// File: tb/tb_input_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_input_frame_loader
//
// Drives input_frame_loader with directed and randomized sample streams. A
// behavioural model of the loader is advanced on every rising edge. A compare
// process checks every DUT output against the model on every falling edge.
// Hand-computed literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_input_frame_loader;

    localparam int N  = 256;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_data  = '0;
    logic                 s_last  = 1'b0;
    logic signed [DW-1:0] frame [0:N-1];
    logic                 ready_for_inf;
    logic                 fp_done = 1'b0;
    logic                 acc_rst;
    logic                 frame_err;
    logic [15:0]          frames_done;
    logic [1:0]           state_dbg;
    logic [7:0]           wr_idx_dbg;

    input_frame_loader #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid_i       (s_valid),
        .s_ready_o       (s_ready),
        .s_data_i        (s_data),
        .s_last_i        (s_last),
        .frame_o         (frame),
        .ready_for_inf_o (ready_for_inf),
        .fp_done_i       (fp_done),
        .acc_rst_o       (acc_rst),
        .frame_err_o     (frame_err),
        .frames_done_o   (frames_done),
        .state_o         (state_dbg),
        .wr_idx_o        (wr_idx_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases of one inference: LOADING samples, STARTING pulse, WAITING for
    // the accelerator, RELEASING it.
    localparam int LOADING   = 0;
    localparam int STARTING  = 1;
    localparam int WAITING   = 2;
    localparam int RELEASING = 3;

    int          m_phase;
    int          m_cnt;
    logic [7:0]  m_frame [0:N-1];
    logic        m_err;
    logic [15:0] m_done;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = LOADING;
                m_cnt   = 0;
                m_err   = 1'b0;
                m_done  = 16'd0;
                for (int i = 0; i < N; i++) m_frame[i] = 8'd0;
            end else begin
                m_err = 1'b0;
                if (m_phase == LOADING) begin
                    if (s_valid) begin
                        m_frame[m_cnt] = s_data;
                        if (m_cnt == N - 1 && s_last) begin
                            m_cnt = 0;
                            m_phase = STARTING;
                        end else if (m_cnt == N - 1 || s_last) begin
                            m_cnt = 0;
                            m_err = 1'b1;
                        end else begin
                            m_cnt = m_cnt + 1;
                        end
                    end
                end else if (m_phase == STARTING) begin
                    m_phase = WAITING;
                end else if (m_phase == WAITING) begin
                    if (fp_done) begin
                        m_phase = RELEASING;
                        m_done  = m_done + 16'd1;
                    end
                end else begin
                    m_phase = LOADING;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                int bad_i;
                chk("s_ready",       s_ready,       m_phase == LOADING);
                chk("ready_for_inf", ready_for_inf, m_phase == STARTING);
                chk("acc_rst",       acc_rst,       m_phase == RELEASING);
                chk("frame_err",     frame_err,     m_err);
                chk("frames_done",   frames_done,   m_done);
                chk("wr_idx",        wr_idx_dbg,    m_cnt);
                bad_i = -1;
                for (int i = 0; i < N; i++)
                    if (bad_i < 0 && frame[i] !== m_frame[i]) bad_i = i;
                n_cmp++;
                if (bad_i >= 0) begin
                    n_bad++;
                    if (n_bad <= 40)
                        $display("FAIL frame[%0d]: got %0h expected %0h at %0t",
                                 bad_i, frame[bad_i], m_frame[bad_i], $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit last, input int idle_pct);
        while ($urandom_range(99) < idle_pct) begin
            s_valid = 1'b0;
            s_last  = 1'(($urandom_range(1)));
            s_data  = 8'($urandom);
            step();
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // pattern 0: ramp (index mod 128); pattern 1: random data
    task automatic send_frame(input int len, input bit close, input int idle_pct, input int pattern);
        for (int k = 0; k < len; k++) begin
            logic [7:0] d;
            d = (pattern == 0) ? 8'(k % 128) : 8'($urandom);
            send(d, close && (k == len - 1), idle_pct);
        end
    endtask

    // Called on the START cycle. valid_mode 0: idle, 1: random, 2: held high.
    task automatic finish_inf(input int wait_cycles, input int valid_mode, input bit start_glitch);
        for (int i = 0; i < wait_cycles; i++) begin
            s_valid = (valid_mode == 2) ? 1'b1 : (valid_mode == 1) ? 1'(($urandom_range(1))) : 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'(($urandom_range(1)));
            fp_done = (i == 0) ? start_glitch : 1'b0;
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        fp_done = 1'b1;
        step();
        chk("lit_acc_rst_pulse", acc_rst, 1);
        chk("lit_s_ready_in_release", s_ready, 0);
        fp_done = 1'(($urandom_range(1)));
        step();
        chk("lit_s_ready_2_after_fp_done", s_ready, 1);
        chk("lit_acc_rst_one_cycle", acc_rst, 0);
        fp_done = 1'b0;
    endtask

    task automatic chk_ramp(input string name);
        int bad_i;
        bad_i = -1;
        for (int i = 0; i < N; i++)
            if (bad_i < 0 && frame[i] !== 8'(i % 128)) bad_i = i;
        n_cmp++;
        if (bad_i >= 0) begin
            n_bad++;
            $display("FAIL %s frame[%0d]: got %0h expected %0h", name, bad_i, frame[bad_i], 8'(bad_i % 128));
        end
    endtask

    task automatic chk_zero(input string name);
        int bad_i;
        bad_i = -1;
        for (int i = 0; i < N; i++)
            if (bad_i < 0 && frame[i] !== 8'd0) bad_i = i;
        n_cmp++;
        if (bad_i >= 0) begin
            n_bad++;
            $display("FAIL %s frame[%0d]: got %0h expected 0", name, bad_i, frame[bad_i]);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #1 rst = 1'b1;
        #1 check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("lit_reset_s_ready", s_ready, 1);
        chk("lit_reset_ready_for_inf", ready_for_inf, 0);
        chk("lit_reset_acc_rst", acc_rst, 0);
        chk("lit_reset_frame_err", frame_err, 0);
        chk("lit_reset_frames_done", frames_done, 0);
        chk("lit_reset_wr_idx", wr_idx_dbg, 0);
        chk_zero("lit_reset_frame");

        // Gap-free ramp frame
        send_frame(N, 1'b1, 0, 0);
        chk("lit_ramp_start", ready_for_inf, 1);
        chk("lit_ramp_s_ready_low", s_ready, 0);
        chk("lit_ramp_frame_200", frame[200], 8'd72);
        chk_ramp("lit_ramp_frame");

        // BUSY with s_valid held high for 50 cycles
        finish_inf(50, 2, 1'b0);
        chk("lit_busy_frames_done", frames_done, 1);
        chk_ramp("lit_frame_held_in_busy");

        // Short frame, then a clean frame
        send_frame(100, 1'b1, 0, 1);
        chk("lit_short_frame_err", frame_err, 1);
        chk("lit_short_wr_idx", wr_idx_dbg, 0);
        chk("lit_short_no_start", ready_for_inf, 0);
        step();
        chk("lit_short_err_one_cycle", frame_err, 0);
        send_frame(N, 1'b1, 0, 1);
        chk("lit_after_short_start", ready_for_inf, 1);
        finish_inf(5, 1, 1'b1);
        chk("lit_frames_done_2", frames_done, 2);

        // Long frame, then the following samples form a new frame
        send_frame(N, 1'b0, 0, 1);
        chk("lit_long_frame_err", frame_err, 1);
        chk("lit_long_no_start", ready_for_inf, 0);
        chk("lit_long_wr_idx", wr_idx_dbg, 0);
        send_frame(N, 1'b1, 0, 1);
        chk("lit_after_long_start", ready_for_inf, 1);
        chk("lit_after_long_err_low", frame_err, 0);
        finish_inf(3, 0, 1'b0);
        chk("lit_frames_done_3", frames_done, 3);

        // Ramp frame with about 30 % idle cycles
        send_frame(N, 1'b1, 30, 0);
        chk("lit_gap_start", ready_for_inf, 1);
        chk_ramp("lit_gap_frame");
        finish_inf($urandom_range(20, 1), 1, 1'b1);
        chk("lit_frames_done_4", frames_done, 4);

        // Randomized mix of good, short and long frames
        for (int it = 0; it < 10; it++) begin
            int kind;
            int gaps;
            kind = $urandom_range(99);
            gaps = $urandom_range(40);
            if (kind < 15) begin
                send_frame($urandom_range(N - 1, 1), 1'b1, gaps, 1);
            end else if (kind < 30) begin
                send_frame(N, 1'b0, gaps, 1);
            end else begin
                send_frame(N, 1'b1, gaps, 1);
                finish_inf($urandom_range(30, 1), $urandom_range(2), 1'($urandom_range(1)));
            end
        end

        // Reset while BUSY
        send_frame(N, 1'b1, 0, 1);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("lit_rst_busy_s_ready", s_ready, 1);
        chk("lit_rst_busy_acc_rst", acc_rst, 0);
        chk("lit_rst_busy_ready_for_inf", ready_for_inf, 0);
        chk("lit_rst_busy_frames_done", frames_done, 0);
        chk("lit_rst_busy_wr_idx", wr_idx_dbg, 0);
        chk_zero("lit_rst_busy_frame");
        fp_done = 1'b1;
        step();
        chk("lit_rst_held_acc_rst", acc_rst, 0);
        step();
        rst = 1'b0;
        fp_done = 1'b0;
        step();
        chk("lit_after_rst_s_ready", s_ready, 1);
        chk("lit_after_rst_acc_rst", acc_rst, 0);
        send_frame(N, 1'b1, 10, 0);
        chk("lit_post_rst_start", ready_for_inf, 1);
        finish_inf(4, 0, 1'b0);
        chk("lit_post_rst_frames_done", frames_done, 1);

        repeat (3) step();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_frame_loader.md
INPUT_FRAME_LOADER -- requirements
Module: input_frame_loader

Interface
REQ-001 Parameter NUM_INPUTS, default 256: samples per frame; must match the accelerator's NUM_INPUTS.
REQ-002 Parameter DATA_WIDTH, default 8: sample width, signed fixed point (3,5).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  loader accepts a sample this cycle.
REQ-007 s_data  input  DATA_WIDTH  signed sample.
REQ-008 s_last  input  1  marks the final sample of a frame.
REQ-009 frame  output  DATA_WIDTH x NUM_INPUTS (unpacked [0:NUM_INPUTS-1])  frame buffer; drives the accelerator inputs.
REQ-010 ready_for_inf  output  1  start pulse to the accelerator.
REQ-011 fp_done  input  1  accelerator forward pass complete (level).
REQ-012 acc_rst  output  1  registered reset pulse returning the accelerator to idle.
REQ-013 frame_err  output  1  one-cycle pulse on a framing error.
REQ-014 frames_done  output  16  count of completed inferences.

Function
REQ-015 States: FILL, START, BUSY, RELEASE; all outputs are driven from registered state, with no combinational path from s_valid to any output.
REQ-016 s_ready = 1 only in FILL; a sample is accepted on any cycle with s_valid & s_ready.
REQ-017 Accepted sample written to frame[wr_idx]; wr_idx (clog2(NUM_INPUTS) bits) increments per accept.
REQ-018 Accept with wr_idx = NUM_INPUTS-1 and s_last = 1: wr_idx -> 0, next state START.
REQ-019 Accept with s_last = 1 and wr_idx < NUM_INPUTS-1 (short frame): frame_err = 1 next cycle, wr_idx -> 0, remain FILL, partial data discarded (entries may hold stale values).
REQ-020 Accept with wr_idx = NUM_INPUTS-1 and s_last = 0 (long frame): frame_err = 1 next cycle, wr_idx -> 0, remain FILL; subsequent samples up to and including the next s_last are not dropped but begin a new frame.
REQ-021 START lasts exactly 1 cycle: ready_for_inf = 1, next state BUSY; ready_for_inf = 0 in all other states.
REQ-022 frame is held constant from entry to START until exit from RELEASE; no writes outside FILL.
REQ-023 BUSY: wait for fp_done = 1, then next state RELEASE; BUSY is unbounded, with no timeout.
REQ-024 RELEASE lasts exactly 1 cycle: acc_rst = 1, frames_done increments (wraps 0xFFFF -> 0x0000), next state FILL.
REQ-025 Consumer must capture accelerator outputs while fp_done is high; accelerator outputs are invalid after acc_rst.
REQ-026 Latency: ready_for_inf asserts on the cycle after the final sample is accepted; s_ready re-asserts 2 cycles after the first cycle fp_done is seen high.
REQ-027 fp_done seen in FILL or START is ignored.
REQ-028 frame_err and ready_for_inf are never asserted in the same cycle.

Reset
REQ-029 On rst: state FILL, wr_idx 0, all frame entries 0, frames_done 0, ready_for_inf/acc_rst/frame_err 0; s_ready = 1 from the first cycle after release.
REQ-030 rst mid-frame or in BUSY: partial data discarded; loader does not pulse acc_rst, since the system reset also resets the accelerator.

Verification
REQ-031 After reset, stream 256 samples (value = index mod 128) with s_last on #255 -> ready_for_inf high for 1 cycle the next cycle; frame[k] = k mod 128; s_ready = 0.
REQ-032 In BUSY, hold s_valid = 1 for 50 cycles, then fp_done = 1 -> no writes occur; acc_rst pulses 1 cycle; frames_done = 1; s_ready = 1 two cycles after fp_done.
REQ-033 s_last on sample #99 -> frame_err pulse; wr_idx = 0; then a clean 256-sample frame -> normal START.
REQ-034 256 samples with no s_last -> frame_err after #255; no ready_for_inf.
REQ-035 Random s_valid gaps (about 30 % idle) -> frame contents identical to the gap-free case.
REQ-036 Assert rst while in BUSY -> all outputs at reset values; no acc_rst; frames_done = 0.
